// File: rtl/tlc_timebase.sv
// tlc_timebase: elapsed-cycle counter, one-second prescaler and farm-road
// sensor conditioning for the traffic light sequencer.
// Optional feature macro: TLC_DEBOUNCE_EN (defined = full debounce FSM,
// undefined = plain edge detect on the synchronized sensor).
module tlc_timebase #(
    parameter int unsigned SEC_TICKS      = 50000000,
    parameter int unsigned DEBOUNCE_TICKS = 500000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RstCount,
    input  logic        FarmSensor,
    input  logic        FarmAck,
    output logic [30:0] Count,
    output logic        SecTick,
    output logic        FarmRequest,
    output logic [1:0]  DbgState
);

    localparam logic [30:0] CNT_MAX = 31'h7FFF_FFFF;

    localparam int unsigned     PRE_W    = $clog2(SEC_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SEC_TICKS - 1);

    logic [30:0]      r_count;
    logic [PRE_W-1:0] r_pre;
    logic             r_sec_tick;
    logic             r_sync_meta;
    logic             r_sync;
    logic             r_farm_req;
    logic             w_rise;

    // Elapsed-cycle counter: clear has priority, saturate instead of wrapping
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count <= '0;
        end else if (RstCount) begin
            r_count <= '0;
        end else if (r_count != CNT_MAX) begin
            r_count <= r_count + 31'd1;
        end
    end

    // Prescaler re-phased by the count clear so ticks align to each phase
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pre      <= '0;
            r_sec_tick <= 1'b0;
        end else if (RstCount) begin
            r_pre      <= '0;
            r_sec_tick <= 1'b0;
        end else if (r_pre == PRE_LAST) begin
            r_pre      <= '0;
            r_sec_tick <= 1'b1;
        end else begin
            r_pre      <= r_pre + PRE_W'(1);
            r_sec_tick <= 1'b0;
        end
    end

    // Two-flop synchronizer for the asynchronous vehicle loop
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= FarmSensor;
            r_sync      <= r_sync_meta;
        end
    end

`ifdef TLC_DEBOUNCE_EN

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_RISE_WAIT = 2'b01;
    localparam logic [1:0] ST_ACTIVE    = 2'b10;
    localparam logic [1:0] ST_FALL_WAIT = 2'b11;

    localparam int unsigned      DCNT_W    = $clog2(DEBOUNCE_TICKS);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]        r_state;
    logic [DCNT_W-1:0] r_dcnt;
    logic [1:0]        w_state_nxt;
    logic [DCNT_W-1:0] w_dcnt_nxt;
    logic              w_dcnt_done;

    assign w_dcnt_done = (r_dcnt == DCNT_LAST);

    // Debounce: a level is accepted only after it holds for the full window;
    // any reversion inside a wait state falls back to the prior stable level
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_rise      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync) begin
                    w_state_nxt = ST_RISE_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end
            ST_RISE_WAIT: begin
                if (!r_sync) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dcnt_done) begin
                    w_state_nxt = ST_ACTIVE;
                    w_rise      = 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + DCNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!r_sync) begin
                    w_state_nxt = ST_FALL_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end
            ST_FALL_WAIT: begin
                if (r_sync) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_dcnt_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dcnt_nxt = r_dcnt + DCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Debounce state and window counter registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    assign DbgState = r_state;

`else

    logic r_sync_d;

    // Delayed copy of the synchronized sensor for rising-edge detection
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync_d <= 1'b0;
        end else begin
            r_sync_d <= r_sync;
        end
    end

    assign w_rise   = r_sync & ~r_sync_d;
    assign DbgState = {r_sync, 1'b0};

    // The debounce window is unused here; keep the parameter referenced so
    // both builds accept the same parameter set
    if (DEBOUNCE_TICKS < 2) begin : g_debounce_unused
    end

`endif

    // Request latch: a new vehicle wins over a simultaneous acknowledge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_farm_req <= 1'b0;
        end else if (w_rise) begin
            r_farm_req <= 1'b1;
        end else if (FarmAck) begin
            r_farm_req <= 1'b0;
        end
    end

    assign Count       = r_count;
    assign SecTick     = r_sec_tick;
    assign FarmRequest = r_farm_req;

endmodule

// File: tb/tb_tlc_timebase.sv
// tb_tlc_timebase: scoreboard bench for tlc_timebase with a run-length
// reference model of the sensor path; works with TLC_DEBOUNCE_EN on or off.
module tb_tlc_timebase;

    localparam int SEC = 4;
    localparam int DEB = 3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        RstCount = 1'b0;
    logic        FarmSensor = 1'b0;
    logic        FarmAck = 1'b0;
    logic [30:0] Count;
    logic        SecTick;
    logic        FarmRequest;
    logic [1:0]  DbgState;

    tlc_timebase #(
        .SEC_TICKS      (SEC),
        .DEBOUNCE_TICKS (DEB)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .RstCount    (RstCount),
        .FarmSensor  (FarmSensor),
        .FarmAck     (FarmAck),
        .Count       (Count),
        .SecTick     (SecTick),
        .FarmRequest (FarmRequest),
        .DbgState    (DbgState)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [30:0] cnt;
        logic        tick;
        logic        req;
        logic [1:0]  dbg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    logic [30:0] m_cnt = '0;
    int          m_since = 0;
    bit          m_hist[$] = '{0, 0, 0, 0};
    bit          m_lvl = 0;
    int          m_run = 0;
    bit          m_req = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs are queued
    task automatic step(input bit rst, input bit rc, input bit sens,
                        input bit ack, input bit frc = 0);
        exp_t e;
        bit   sync_b;
        bit   syncd_b;
        bit   rise;
        @(negedge Clk);
        if (frc) begin
            force dut.r_count = 31'h7FFF_FFFE;
            #1;
            release dut.r_count;
            m_cnt = 31'h7FFF_FFFE;
        end
        Rst        = rst;
        RstCount   = rc;
        FarmSensor = sens;
        FarmAck    = ack;
        if (rst) begin
            m_cnt   = '0;
            m_since = 0;
            m_hist  = '{0, 0, 0, 0};
            m_lvl   = 0;
            m_run   = 0;
            m_req   = 0;
            e.tick  = 1'b0;
            e.dbg   = 2'b00;
        end else begin
            m_hist.push_back(sens);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            sync_b  = m_hist[$-2];
            syncd_b = m_hist[$-3];
            if (rc) begin
                m_cnt   = '0;
                m_since = 0;
                e.tick  = 1'b0;
            end else begin
                if (m_cnt != 31'h7FFF_FFFF) m_cnt = m_cnt + 31'd1;
                m_since++;
                e.tick = (m_since % SEC == 0);
            end
            rise = 0;
`ifdef TLC_DEBOUNCE_EN
            // level flips after DEB+1 consecutive samples differing from it
            if (sync_b != m_lvl) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl = sync_b;
                    m_run = 0;
                    rise  = sync_b;
                end
            end else begin
                m_run = 0;
            end
            e.dbg = {m_lvl, (m_run != 0)};
`else
            rise  = sync_b && !syncd_b;
            e.dbg = {m_hist[$-1], 1'b0};
`endif
            if (rise) m_req = 1;
            else if (ack) m_req = 0;
        end
        e.cnt = m_cnt;
        e.req = m_req;
        exp_q.push_back(e);
    endtask

    // Monitor: every clock presents outputs; compare against the queue
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("Count", {1'b0, Count}, {1'b0, e.cnt});
            chk("SecTick", {31'b0, SecTick}, {31'b0, e.tick});
            chk("FarmRequest", {31'b0, FarmRequest}, {31'b0, e.req});
            chk("DbgState", {30'b0, DbgState}, {30'b0, e.dbg});
        end
    end

    initial begin
        bit s;
        // reset and free run
        repeat (2) step(1, 0, 0, 0);
        repeat (12) step(0, 0, 0, 0);
        // clear at Count == 10
        step(0, 1, 0, 0);
        while (m_cnt != 31'd10) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (9) step(0, 0, 0, 0);
        // saturation, then clear from saturation
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        // steady sensor, ack, release
        repeat (10) step(0, 0, 1, 0);
        repeat (2) step(0, 0, 1, 1);
        repeat (8) step(0, 0, 0, 0);
        // short glitch
        repeat (2) step(0, 0, 1, 0);
        repeat (8) step(0, 0, 0, 0);
        // ack held through the rise cycle, later ack clears
        repeat (10) step(0, 0, 1, 1);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 1, 0);
        repeat (8) step(0, 0, 0, 0);
        // one-cycle pulse
        step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        // reset during a pending rise
        repeat (4) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        repeat (8) step(0, 0, 1, 0);
        repeat (8) step(0, 0, 0, 0);
        // randomized traffic
        s = 0;
        repeat (800) begin
            if ($urandom_range(0, 4) == 0) s = ~s;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 39) == 0),
                 s,
                 ($urandom_range(0, 7) == 0));
        end
        repeat (2) @(negedge Clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlc_timebase.md
# tlc_timebase

Timebase and sensor front end for the traffic light controller, sitting directly upstream of the light-sequencing FSM. It generates the 31-bit elapsed-cycle `Count` that the FSM compares against its phase thresholds, and clears it on the FSM's `RstCount` strobe. It also conditions the raw farm-road vehicle sensor into a latched, acknowledged `FarmRequest`, and emits a one-second tick for display and debug.

## Interface

Parameters:
- `SEC_TICKS`, 50000000: clock cycles per second at 50 MHz. Legal range 2..2^31-1.
- `DEBOUNCE_TICKS`, 500000: cycles the synchronized sensor must stay stable before a level change is accepted (10 ms). Legal range 2..2^20.

Ports:
- `Clk`  in  1: single system clock. All logic is on its rising edge.
- `Rst`  in  1: synchronous, active-high reset.
- `RstCount`  in  1: count clear strobe from the sequencing FSM, sampled at the edge.
- `FarmSensor`  in  1: raw, asynchronous vehicle-loop input (1 = vehicle present).
- `FarmAck`  in  1: one-cycle acknowledge from the FSM that clears `FarmRequest`.
- `Count`  out  31: elapsed cycles since the last clear.
- `SecTick`  out  1: one-cycle pulse every `SEC_TICKS` cycles.
- `FarmRequest`  out  1: latched vehicle request.
- `DbgState`  out  2: debounce state, for debug.

## Operation

- **Count:**
  - On each edge, `Count` takes `Rst` ? 0 : `RstCount` ? 0 : (`Count` == 2^31-1 ? `Count` : `Count`+1).
  - Count saturates at 2^31-1 and never wraps.
  - `RstCount` has priority over increment.
- **Prescaler:**
  - Internal counter `pre`, range 0..`SEC_TICKS`-1.
  - `SecTick` = 1 on the edge where `pre` wraps from `SEC_TICKS`-1 to 0; otherwise 0.
  - `RstCount` clears `pre` to 0 and suppresses `SecTick` that cycle, so ticks stay phase-aligned to each FSM phase.
- **Synchronizer:** two-flop synchronizer on `FarmSensor`, producing `sync`. Both flops reset to 0.
- **Debounce FSM** (`DbgState` encoding):
  - IDLE = 00:
    - `sync`=1 -> RISE_WAIT and clear `dcnt`.
  - RISE_WAIT = 01:
    - `sync`=0 -> IDLE.
    - else if `dcnt` == `DEBOUNCE_TICKS`-1 -> ACTIVE, and pulse internal `rise`.
    - else `dcnt`+1.
  - ACTIVE = 10:
    - `sync`=0 -> FALL_WAIT and clear `dcnt`.
  - FALL_WAIT = 11:
    - `sync`=1 -> ACTIVE with no new `rise`.
    - else if `dcnt` == `DEBOUNCE_TICKS`-1 -> IDLE.
    - else `dcnt`+1.
- **Request latch:**
  - `FarmRequest` sets on `rise` and clears on `FarmAck`.
  - If `rise` and `FarmAck` occur in the same cycle, set wins (a new vehicle must not be lost).
  - `FarmAck` while `FarmRequest`=0 has no effect.

## Timing

- **Reset values:**
  - `Count`=0, `SecTick`=0, `FarmRequest`=0, `DbgState`=00.
  - `pre`, `dcnt` and both synchronizer flops = 0.
- **`Rst` vs. `RstCount`:** `Rst` overrides everything, including an in-flight debounce. `Rst` asserted mid-RISE_WAIT returns to IDLE with no request.
- **Count clear:** `Count` clears at the same edge `RstCount` is sampled. The FSM's combinational `RstCount` (Count == threshold) therefore sees the threshold value for exactly one cycle. The sequence is N, 0, 1, 2, …
- **Sensor latency:** from `FarmSensor` rising (stable) to `FarmRequest`=1 is 2 synchronizer cycles + 1 (IDLE->RISE_WAIT) + `DEBOUNCE_TICKS` cycles, i.e. `DEBOUNCE_TICKS`+3 edges.
- **Release:** a release is accepted after `DEBOUNCE_TICKS` stable-low cycles. `FarmRequest` is not affected by release, only by `FarmAck`.
- **Glitches:** a glitch shorter than `DEBOUNCE_TICKS` cycles in either WAIT state returns to the prior stable state and produces no `rise`.

## Configuration

- **`TLC_DEBOUNCE_EN` defined:** the debounce FSM operates as described above.
- **`TLC_DEBOUNCE_EN` undefined:**
  - The FSM and `dcnt` are removed.
  - `rise` = `sync` & ~`sync_d` (one-flop edge detect on the synchronized input), giving latency 3 edges.
  - `DbgState` = {`sync`, 1'b0}.
  - The latch and `FarmAck` priority are unchanged.

## Test plan

All scenarios use `SEC_TICKS`=4 and `DEBOUNCE_TICKS`=3.

1. Hold `Rst`=1 for 2 cycles, then release -> `Count` reads 0,1,2,3,…; `SecTick` is high on the cycles where `pre` wraps (every 4th edge); all other outputs are 0.
2. Pulse `RstCount` when `Count`=10 -> next value is 0, then 1; the `SecTick` phase restarts with the first tick 4 edges later.
3. Force `Count` to 2^31-2 and run 3 cycles -> `Count` holds at 2^31-1 (0x7FFFFFFF) with no wrap.
4. Drive `FarmSensor`=1 steadily -> `FarmRequest` rises on edge 6; `DbgState` goes 00->01->10.
5. Drive a 2-cycle sensor glitch -> `DbgState` visits 01 and returns to 00; `FarmRequest` stays 0.
6. Assert `FarmAck` on the exact cycle `rise` fires -> `FarmRequest`=1. A later `FarmAck` -> `FarmRequest`=0 on the next edge.
7. With `TLC_DEBOUNCE_EN` undefined, a 1-cycle-wide pulse that survives the synchronizer -> `FarmRequest`=1 three edges after assertion.
